// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - opcode classes, FSM states and decode helpers for the issue controller
// Contents: opcode constants, op_class_e, state_e, opClass(), srcUse(), writesRd().
package pipeline_pkg;

    localparam logic [3:0] OP_ALU_HI = 4'h7;
    localparam logic [3:0] OP_MOVI   = 4'h8;
    localparam logic [3:0] OP_LOAD   = 4'h9;
    localparam logic [3:0] OP_STORE  = 4'hA;
    localparam logic [3:0] OP_BR_LO  = 4'hB;
    localparam logic [3:0] OP_BR_HI  = 4'hD;
    localparam logic [3:0] OP_NOP    = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MOVI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_NOP,
        CLS_HALT
    } op_class_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    function automatic op_class_e opClass(input logic [3:0] opcode);
        op_class_e cls;
        if (opcode <= OP_ALU_HI) begin
            cls = CLS_ALU;
        end else if (opcode == OP_MOVI) begin
            cls = CLS_MOVI;
        end else if (opcode == OP_LOAD) begin
            cls = CLS_LOAD;
        end else if (opcode == OP_STORE) begin
            cls = CLS_STORE;
        end else if (opcode >= OP_BR_LO && opcode <= OP_BR_HI) begin
            cls = CLS_BRANCH;
        end else if (opcode == OP_NOP) begin
            cls = CLS_NOP;
        end else begin
            cls = CLS_HALT;
        end
        return cls;
    endfunction

    // Returns {readsRs1, readsRs2}.
    function automatic logic [1:0] srcUse(input logic [3:0] opcode);
        logic [1:0] use_bits;
        case (opClass(opcode))
            CLS_ALU, CLS_STORE, CLS_BRANCH: use_bits = 2'b11;
            CLS_LOAD:                       use_bits = 2'b10;
            default:                        use_bits = 2'b00;
        endcase
        return use_bits;
    endfunction

    function automatic logic writesRd(input logic [3:0] opcode);
        op_class_e cls;
        cls = opClass(opcode);
        return (cls == CLS_ALU) || (cls == CLS_MOVI) || (cls == CLS_LOAD);
    endfunction

endpackage

// File: rtl/inflight_scoreboard.sv
// rtl/inflight_scoreboard.sv - shift-register scoreboard of in-flight destination registers
// Ports: clock/reset; push_valid/push_rd load slot 1; rs1/rs2 with use_rs1/use_rs2 are the
// decode sources; raw_hazard flags a source matching slots 1..LATENCY-1; pendingMask is the
// one-hot OR over those slots; any_inflight is high while any slot 1..LATENCY is valid.
module inflight_scoreboard #(
    parameter int ADDRESSWIDTH = 4,
    parameter int REGNUM       = 16,
    parameter int LATENCY      = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push_valid,
    input  logic [ADDRESSWIDTH-1:0] push_rd,
    input  logic [ADDRESSWIDTH-1:0] rs1,
    input  logic [ADDRESSWIDTH-1:0] rs2,
    input  logic                    use_rs1,
    input  logic                    use_rs2,
    output logic                    raw_hazard,
    output logic [REGNUM-1:0]       pendingMask,
    output logic                    any_inflight
);

    logic [LATENCY:1]        slot_valid_q;
    logic [LATENCY:1]        slot_valid_d;
    logic [ADDRESSWIDTH-1:0] slot_rd_q [1:LATENCY];
    logic [ADDRESSWIDTH-1:0] slot_rd_d [1:LATENCY];

    always_comb begin
        slot_valid_d[1] = push_valid;
        slot_rd_d[1]    = push_valid ? push_rd : '0;
        for (int k = 2; k <= LATENCY; k++) begin
            slot_valid_d[k] = slot_valid_q[k-1];
            slot_rd_d[k]    = slot_rd_q[k-1];
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 1; k <= LATENCY; k++) begin
            if (reset) begin
                slot_valid_q[k] <= 1'b0;
                slot_rd_q[k]    <= '0;
            end else begin
                slot_valid_q[k] <= slot_valid_d[k];
                slot_rd_q[k]    <= slot_rd_d[k];
            end
        end
    end

    // The last slot is writing the register file on the falling edge, so decode
    // already sees its value and it neither stalls nor counts as pending.
    always_comb begin
        raw_hazard  = 1'b0;
        pendingMask = '0;
        for (int k = 1; k < LATENCY; k++) begin
            if (slot_valid_q[k]) begin
                pendingMask = pendingMask | (REGNUM'(1) << slot_rd_q[k]);
                if ((use_rs1 && slot_rd_q[k] == rs1) || (use_rs2 && slot_rd_q[k] == rs2)) begin
                    raw_hazard = 1'b1;
                end
            end
        end
    end

    assign any_inflight = |slot_valid_q;

endmodule

// File: rtl/decode_hazard_control.sv
// rtl/decode_hazard_control.sv - decode-stage issue controller: hazard stall, flush, halt drain
// Ports: clock, reset (sync, active-high); instrValid/instruction/flush from decode;
// stall holds fetch/decode; issueValid is execute's valid; pendingMask lists registers with
// outstanding writes; hazardCount counts RUN stall cycles (saturating); halted after HALT drains.
module decode_hazard_control
    import pipeline_pkg::*;
#(
    parameter int ADDRESSWIDTH     = 4,
    parameter int REGNUM           = 16,
    parameter int OPCODEWIDTH      = 4,
    parameter int INSTRUCTIONWIDTH = 16,
    parameter int LATENCY          = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        instrValid,
    input  logic [INSTRUCTIONWIDTH-1:0] instruction,
    input  logic                        flush,
    output logic                        stall,
    output logic                        issueValid,
    output logic [REGNUM-1:0]           pendingMask,
    output logic [15:0]                 hazardCount,
    output logic                        halted
);

    logic [OPCODEWIDTH-1:0]  opcode;
    logic [ADDRESSWIDTH-1:0] rd;
    logic [ADDRESSWIDTH-1:0] rs2;
    logic [ADDRESSWIDTH-1:0] rs1;
    logic [1:0]              src_use;
    logic                    raw_hazard;
    logic                    hazard;
    logic                    any_inflight;

    state_e      state_q;
    state_e      state_d;
    logic [15:0] hazard_count_q;
    logic [15:0] hazard_count_d;

    assign opcode  = instruction[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH];
    assign rd      = instruction[3*ADDRESSWIDTH-1 -: ADDRESSWIDTH];
    assign rs2     = instruction[2*ADDRESSWIDTH-1 -: ADDRESSWIDTH];
    assign rs1     = instruction[ADDRESSWIDTH-1:0];
    assign src_use = srcUse(opcode);

    inflight_scoreboard #(
        .ADDRESSWIDTH(ADDRESSWIDTH),
        .REGNUM      (REGNUM),
        .LATENCY     (LATENCY)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .push_valid  (issueValid && writesRd(opcode)),
        .push_rd     (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .use_rs1     (src_use[1]),
        .use_rs2     (src_use[0]),
        .raw_hazard  (raw_hazard),
        .pendingMask (pendingMask),
        .any_inflight(any_inflight)
    );

    // A flushed instruction is dropped, so it can never be the cause of a stall.
    assign hazard = instrValid && !flush && raw_hazard;

    always_comb begin
        state_d        = state_q;
        hazard_count_d = hazard_count_q;
        stall          = 1'b0;
        issueValid     = 1'b0;
        halted         = 1'b0;
        case (state_q)
            ST_RUN: begin
                issueValid = instrValid && !flush && !hazard;
                stall      = hazard;
                if (stall && hazard_count_q != 16'hFFFF) begin
                    hazard_count_d = hazard_count_q + 16'd1;
                end
                if (issueValid && opcode == OP_HALT) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                stall = 1'b1;
                if (!any_inflight) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_RUN;
            hazard_count_q <= '0;
        end else begin
            state_q        <= state_d;
            hazard_count_q <= hazard_count_d;
        end
    end

    assign hazardCount = hazard_count_q;

endmodule

// File: doc/decode_hazard_control.md
# decode_hazard_control

Scoreboard-based issue controller that sits beside the decode stage and decides, every cycle, whether the instruction in decode may issue to execute or must be held. It tracks destination registers of in-flight instructions, stalls on read-after-write hazards the register file cannot resolve, handles branch flushes, and sequences a clean halt once the pipeline drains. Fetch and the decode pipeline register obey `stall`; execute consumes `issueValid` as its valid bit.

## Interface
Parameters:
- `ADDRESSWIDTH`, 4: register address width.
- `REGNUM`, 16: number of architectural registers.
- `OPCODEWIDTH`, 4: opcode width.
- `INSTRUCTIONWIDTH`, 16: instruction width.
- `LATENCY`, 3: cycles from issue to the register-file write; must be ≥ 2.

Ports:
- `clock`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `instrValid`  in  1  Decode holds a real instruction.
- `instruction`  in  `INSTRUCTIONWIDTH`  Decode-stage instruction. Fields: opcode [15:12], rd [11:8], rs2 [7:4], rs1 [3:0].
- `flush`  in  1  Branch taken; kill the instruction in decode this cycle.
- `stall`  out  1  Hold fetch and decode registers.
- `issueValid`  out  1  Decode instruction issues to execute this cycle.
- `pendingMask`  out  `REGNUM`  Bit r set while some in-flight instruction will write r.
- `hazardCount`  out  16  Saturating count of data-hazard stall cycles.
- `halted`  out  1  High once a HALT has fully drained.

## Operation
- Opcode classes:
  - 0x0–0x7 ALU: reads rs1 and rs2, writes rd.
  - 0x8 MOVI: writes rd, reads nothing.
  - 0x9 LOAD: reads rs1, writes rd.
  - 0xA STORE: reads rs1 and rs2, no write.
  - 0xB–0xD branch: reads rs1 and rs2, no write.
  - 0xE NOP: no reads, no write.
  - 0xF HALT: no reads, no write.
- Tracking pipe: slots S[1..LATENCY], each holding {valid, rd}.
  - Every cycle, S[k+1] ← S[k].
  - S[1] ← {writes-rd class, rd} when `issueValid`; otherwise S[1] ← 0.
  - S[LATENCY] is the instruction writing the register file this cycle.
- Hazard: `instrValid`, not `flush`, and a read source equals the rd of a valid S[k] with k < LATENCY.
  - S[LATENCY] is exempt because the register file writes on the falling edge, before decode samples.
  - Register 0 is not special.
- `pendingMask` is the OR of the one-hot rd over valid S[1..LATENCY-1].
- FSM states RUN, DRAIN, HALTED:
  - RUN: `issueValid` = `instrValid` & !`flush` & !hazard. `stall` = hazard & !`flush`. A flushed instruction is dropped, not stalled.
  - RUN→DRAIN: when a HALT issues.
  - DRAIN: `issueValid` = 0, `stall` = 1, `flush` is ignored. Move to HALTED on the first cycle all slots are invalid.
  - HALTED: `issueValid` = 0, `stall` = 1, `halted` = 1. Leave only on `reset`.
- `hazardCount` increments each RUN cycle with `stall` = 1 and saturates at 0xFFFF.

## Timing
- Outputs `stall`, `issueValid`, and `hazardCount` increment decisions are combinational from the current instruction and registered state, with no added latency.
- Slots, FSM, and counter are registered.
- Worst-case stall for a back-to-back dependency is LATENCY−1 cycles. With LATENCY = 3, dependent ALU ops issue with 2 bubbles between them.
- Reset, including mid-stall or mid-DRAIN, produces this state on the next edge:
  - all slots invalid, FSM = RUN, `hazardCount` = 0;
  - hence `pendingMask` = 0, `halted` = 0, `stall` = 0, and `issueValid` = `instrValid` (subject to `flush`).
- `flush` coincident with a hazard: the flush wins. `stall` = 0 and `issueValid` = 0; no hazard count.
- `flush` coincident with a HALT in decode: the HALT is killed and the FSM stays in RUN.
- Duplicate rd across multiple slots is legal; the mask bit stays set until the last one retires from S[LATENCY-1].

## Structure
- Package `pipeline_pkg`:
  - opcode constants and class enum;
  - FSM state typedef;
  - function `srcUse(opcode)` returning {readsRs1, readsRs2};
  - function `writesRd(opcode)`.
- Sub-module `inflight_scoreboard`: the slot shift register, `pendingMask` generation, and the hazard compare.
- The top level holds the FSM, issue logic, and counter.

## Test plan
- Independent ALU ops 0x1123, 0x1456 every cycle → `issueValid` = 1 each cycle, `stall` = 0, `hazardCount` = 0.
- 0x1300 (writes r3), then 0x2403 (reads r3) → `stall` high for exactly 2 cycles, the second op issues on cycle 3, `hazardCount` = 2.
- Writer of r5, two NOPs, then a reader of r5 → no stall, because the S[LATENCY] exemption applies.
- Reader stalled on r3 while `flush` = 1 → `issueValid` = 0, `stall` = 0, `hazardCount` unchanged.
- HALT 0xF000 issued with two writers in flight → DRAIN for 3 cycles with `stall` = 1, then `halted` = 1; `reset` returns everything to RUN with zeroed outputs.
- Force 65,540 hazard stall cycles → `hazardCount` = 0xFFFF and holds.
